latch_mem_write_ctrl: RTL and testbench

//  Write-side controller for the 16-word latch memory column whose read path is a one-hot
//  RWL-selected NAND/NOR tree. Accepts write requests over a valid/ready handshake and

---
 rtl/latch_mem_pkg.sv | 27 ++
 rtl/wwl_decode.sv | 29 ++
 rtl/latch_mem_write_ctrl.sv | 125 ++++++++++++
 tb/tb_latch_mem_write_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_mem_pkg.sv
// ---------------------------------------------------------------------------
// latch_mem_pkg : shared defaults and write-FSM state type for the latch column
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package latch_mem_pkg;

  localparam int c_depth_default = 16;
  localparam int c_aw_default    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } wr_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wwl_decode.sv
// ---------------------------------------------------------------------------
// wwl_decode : address to one-hot write-word-line decoder with range flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wwl_decode
  import latch_mem_pkg::*;
#(
  parameter int DEPTH = c_depth_default,
  parameter int AW    = c_aw_default
) (
  input  logic [AW-1:0]    addr,
  input  logic             en,
  output logic [DEPTH-1:0] wwl,
  output logic             in_range
);

  assign in_range = ({1'b0, addr} < (AW+1)'(DEPTH));

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_dec
      assign wwl[i] = en & (addr == AW'(i));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/latch_mem_write_ctrl.sv
// ---------------------------------------------------------------------------
// latch_mem_write_ctrl : sequences data setup, one-hot WWL pulse and hold
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module latch_mem_write_ctrl
  import latch_mem_pkg::*;
#(
  parameter int DEPTH     = c_depth_default,
  parameter int AW        = $clog2(DEPTH),
  parameter int WIDTH     = 1,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] wdata,
  output logic [DEPTH-1:0] wwl,
  output logic             wr_done,
  output logic             wr_err
);

  localparam int c_cnt_w = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);
  localparam logic [c_cnt_w-1:0] c_setup_ld = c_cnt_w'(SETUP_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_pulse_ld = c_cnt_w'(PULSE_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_hold_ld  = c_cnt_w'(HOLD_CYC - 1);

  wr_state_t          r_state, w_state_n;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_n;
  logic [AW-1:0]      r_addr;
  logic [AW-1:0]      w_dec_addr;
  logic [DEPTH-1:0]   w_dec_wwl;
  logic               w_in_range;
  logic               w_accept;
  logic               w_cnt_zero;

  assign wr_ready   = (r_state == IDLE) & ~rst;
  assign w_accept   = wr_valid & (r_state == IDLE);
  assign w_cnt_zero = (r_cnt == '0);

  // In IDLE the decoder only judges the incoming address; later it drives the captured one.
  assign w_dec_addr = (r_state == IDLE) ? wr_addr : r_addr;

  wwl_decode #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_wwl_decode (
    .addr     (w_dec_addr),
    .en       (w_state_n == PULSE),
    .wwl      (w_dec_wwl),
    .in_range (w_in_range)
  );

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept && w_in_range) begin
          w_state_n = SETUP;
          w_cnt_n   = c_setup_ld;
        end
      end
      SETUP: begin
        if (w_cnt_zero) begin
          w_state_n = PULSE;
          w_cnt_n   = c_pulse_ld;
        end else begin
          w_cnt_n = r_cnt - c_cnt_w'(1);
        end
      end
      PULSE: begin
        if (w_cnt_zero) begin
          w_state_n = HOLD;
          w_cnt_n   = c_hold_ld;
        end else begin
          w_cnt_n = r_cnt - c_cnt_w'(1);
        end
      end
      HOLD: begin
        if (w_cnt_zero) begin
          w_state_n = IDLE;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt - c_cnt_w'(1);
        end
      end
      default: begin
        w_state_n = IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      wwl     <= '0;
      wdata   <= '0;
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      wwl     <= w_dec_wwl;
      wr_done <= (r_state == HOLD) && w_cnt_zero;
      wr_err  <= w_accept && !w_in_range;
      if (w_accept && w_in_range) begin
        r_addr <= wr_addr;
        wdata  <= wr_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_latch_mem_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_latch_mem_write_ctrl : directed vector bench for the latch write controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_latch_mem_write_ctrl;

  logic       clk;
  logic       rst;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [0:0] wr_data;

  logic        ready_a, done_a, err_a;
  logic [0:0]  wdata_a;
  logic [15:0] wwl_a;
  logic        ready_b, done_b, err_b;
  logic [0:0]  wdata_b;
  logic [15:0] wwl_b;
  logic        ready_c, done_c, err_c;
  logic [0:0]  wdata_c;
  logic [11:0] wwl_c;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 0;

  latch_mem_write_ctrl u_dut_a (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(ready_a),
    .wr_addr(wr_addr), .wr_data(wr_data), .wdata(wdata_a), .wwl(wwl_a),
    .wr_done(done_a), .wr_err(err_a)
  );

  latch_mem_write_ctrl #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u_dut_b (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(ready_b),
    .wr_addr(wr_addr), .wr_data(wr_data), .wdata(wdata_b), .wwl(wwl_b),
    .wr_done(done_b), .wr_err(err_b)
  );

  latch_mem_write_ctrl #(.DEPTH(12)) u_dut_c (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(ready_c),
    .wr_addr(wr_addr), .wr_data(wr_data), .wdata(wdata_c), .wwl(wwl_c),
    .wr_done(done_c), .wr_err(err_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input bit ok, input string nm, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", nm, detail);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic        valid;
    logic [3:0]  addr;
    logic        data;
    logic        ready;
    logic [15:0] wwl;
    logic        wdata;
    logic        done;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic v, input logic [3:0] a, input logic d,
                              input logic r, input logic [15:0] w, input logic wd,
                              input logic dn);
    vec_t t;
    t.valid = v; t.addr = a; t.data = d;
    t.ready = r; t.wwl = w; t.wdata = wd; t.done = dn;
    return t;
  endfunction

  // Per-cycle invariants for all instances while random traffic runs.
  logic [15:0] p_wwl_a, p_wwl_b, p_wwl_c;
  logic        p_wd_a, p_wd_b, p_wd_c;
  logic        p_rdy_a, p_rdy_b, p_rdy_c;

  task automatic mon_chk(input string nm, input logic [15:0] w, input logic [15:0] pw,
                         input logic wd, input logic pwd, input logic prdy);
    bit ok;
    ok = $onehot0(w) && (!((|w) && (|pw)) || (wd == pwd)) && (prdy || (wd == pwd));
    chk(ok, nm, $sformatf("wwl=%h prev_wwl=%h wdata=%0d prev_wdata=%0d prev_ready=%0d",
                          w, pw, wd, pwd, prdy));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_chk("mon_a", wwl_a, p_wwl_a, wdata_a[0], p_wd_a, p_rdy_a);
      mon_chk("mon_b", wwl_b, p_wwl_b, wdata_b[0], p_wd_b, p_rdy_b);
      mon_chk("mon_c", {4'h0, wwl_c}, p_wwl_c, wdata_c[0], p_wd_c, p_rdy_c);
    end
    p_wwl_a <= wwl_a;         p_wd_a <= wdata_a[0]; p_rdy_a <= ready_a;
    p_wwl_b <= wwl_b;         p_wd_b <= wdata_b[0]; p_rdy_b <= ready_b;
    p_wwl_c <= {4'h0, wwl_c}; p_wd_c <= wdata_c[0]; p_rdy_c <= ready_c;
  end

  initial begin
    // single write to addr 5, then three back-to-back writes to 0,1,2
    vecs[0]  = mk(1, 5, 1,  1, 16'h0000, 0, 0);
    vecs[1]  = mk(0, 0, 0,  0, 16'h0000, 1, 0);
    vecs[2]  = mk(0, 0, 0,  0, 16'h0020, 1, 0);
    vecs[3]  = mk(0, 0, 0,  0, 16'h0000, 1, 0);
    vecs[4]  = mk(0, 0, 0,  1, 16'h0000, 1, 1);
    vecs[5]  = mk(0, 0, 0,  1, 16'h0000, 1, 0);
    vecs[6]  = mk(1, 0, 0,  1, 16'h0000, 1, 0);
    vecs[7]  = mk(1, 1, 1,  0, 16'h0000, 0, 0);
    vecs[8]  = mk(1, 1, 1,  0, 16'h0001, 0, 0);
    vecs[9]  = mk(1, 1, 1,  0, 16'h0000, 0, 0);
    vecs[10] = mk(1, 1, 1,  1, 16'h0000, 0, 1);
    vecs[11] = mk(1, 2, 0,  0, 16'h0000, 1, 0);
    vecs[12] = mk(1, 2, 0,  0, 16'h0002, 1, 0);
    vecs[13] = mk(1, 2, 0,  0, 16'h0000, 1, 0);
    vecs[14] = mk(1, 2, 0,  1, 16'h0000, 1, 1);
    vecs[15] = mk(0, 0, 0,  0, 16'h0000, 0, 0);
    vecs[16] = mk(0, 0, 0,  0, 16'h0004, 0, 0);
    vecs[17] = mk(0, 0, 0,  0, 16'h0000, 0, 0);
    vecs[18] = mk(0, 0, 0,  1, 16'h0000, 0, 1);
    vecs[19] = mk(0, 0, 0,  1, 16'h0000, 0, 0);

    do_reset();
    @(negedge clk);
    chk(ready_a && wwl_a == 0 && wdata_a == 0 && !done_a && !err_a, "reset_a",
        $sformatf("rdy=%0d wwl=%h wd=%0d done=%0d err=%0d exp 1/0/0/0/0",
                  ready_a, wwl_a, wdata_a, done_a, err_a));
    chk(ready_b && wwl_b == 0 && wdata_b == 0 && !done_b && !err_b, "reset_b",
        $sformatf("rdy=%0d wwl=%h wd=%0d done=%0d err=%0d exp 1/0/0/0/0",
                  ready_b, wwl_b, wdata_b, done_b, err_b));
    chk(ready_c && wwl_c == 0 && wdata_c == 0 && !done_c && !err_c, "reset_c",
        $sformatf("rdy=%0d wwl=%h wd=%0d done=%0d err=%0d exp 1/0/0/0/0",
                  ready_c, wwl_c, wdata_c, done_c, err_c));
    @(posedge clk); #1;

    // vector table on the default-parameter instance
    for (int i = 0; i < 20; i++) begin
      wr_valid = vecs[i].valid;
      wr_addr  = vecs[i].addr;
      wr_data  = vecs[i].data;
      @(negedge clk);
      chk(ready_a == vecs[i].ready && wwl_a == vecs[i].wwl && wdata_a[0] == vecs[i].wdata &&
          done_a == vecs[i].done && !err_a, $sformatf("vec%0d", i),
          $sformatf("rdy=%0d wwl=%h wd=%0d done=%0d err=%0d exp rdy=%0d wwl=%h wd=%0d done=%0d err=0",
                    ready_a, wwl_a, wdata_a, done_a, err_a,
                    vecs[i].ready, vecs[i].wwl, vecs[i].wdata, vecs[i].done));
      @(posedge clk); #1;
    end

    // long phases: SETUP 2, PULSE 3, HOLD 2, address 15
    do_reset();
    wr_valid = 1; wr_addr = 15; wr_data = 1;
    @(negedge clk);
    chk(ready_b, "long_accept", $sformatf("rdy=%0d exp 1", ready_b));
    @(posedge clk); #1;
    wr_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      logic [15:0] ew;
      ew = (k >= 3 && k <= 5) ? 16'h8000 : 16'h0000;
      @(negedge clk);
      chk(wwl_b == ew && wdata_b == 1 && ready_b == (k == 8) && done_b == (k == 8),
          $sformatf("long_c%0d", k),
          $sformatf("rdy=%0d wwl=%h wd=%0d done=%0d exp rdy=%0d wwl=%h wd=1 done=%0d",
                    ready_b, wwl_b, wdata_b, done_b, (k == 8), ew, (k == 8)));
      @(posedge clk); #1;
    end

    // out-of-range address on the 12-word instance
    do_reset();
    wr_valid = 1; wr_addr = 3; wr_data = 1;
    @(posedge clk); #1;
    wr_valid = 0;
    repeat (3) begin @(posedge clk); #1; end
    wr_valid = 1; wr_addr = 13; wr_data = 0;
    @(negedge clk);
    chk(ready_c && done_c && wdata_c == 1, "oor_pre",
        $sformatf("rdy=%0d done=%0d wd=%0d exp 1/1/1", ready_c, done_c, wdata_c));
    @(posedge clk); #1;
    wr_addr = 7; wr_data = 0;
    @(negedge clk);
    chk(err_c && ready_c && wwl_c == 0 && wdata_c == 1 && !done_c, "oor_err",
        $sformatf("err=%0d rdy=%0d wwl=%h wd=%0d done=%0d exp 1/1/000/1/0",
                  err_c, ready_c, wwl_c, wdata_c, done_c));
    @(posedge clk); #1;
    wr_valid = 0;
    @(negedge clk);
    chk(!err_c && !ready_c && wdata_c == 0, "oor_next_accept",
        $sformatf("err=%0d rdy=%0d wd=%0d exp 0/0/0", err_c, ready_c, wdata_c));
    @(posedge clk); #1;
    @(negedge clk);
    chk(wwl_c == 12'h080, "oor_next_pulse", $sformatf("wwl=%h exp 080", wwl_c));

    // asynchronous reset in the middle of the pulse
    do_reset();
    wr_valid = 1; wr_addr = 9; wr_data = 1;
    @(posedge clk); #1;
    wr_valid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk(wwl_a == 16'h0200, "rst_pulse_on", $sformatf("wwl=%h exp 0200", wwl_a));
    #2 rst = 1'b1;
    #1;
    chk(wwl_a == 0 && !ready_a, "rst_async",
        $sformatf("wwl=%h rdy=%0d exp 0000/0", wwl_a, ready_a));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(ready_a && wwl_a == 0 && !done_a && !err_a, "rst_after",
        $sformatf("rdy=%0d wwl=%h done=%0d err=%0d exp 1/0000/0/0", ready_a, wwl_a, done_a, err_a));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk(ready_a && !done_a && !err_a, $sformatf("rst_quiet%0d", k),
          $sformatf("rdy=%0d done=%0d err=%0d exp 1/0/0", ready_a, done_a, err_a));
    end
    @(posedge clk); #1;

    // random request traffic with invariant monitors
    do_reset();
    @(negedge clk);
    mon_en = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 300; k++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = 4'($urandom_range(0, 15));
      wr_data  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    wr_valid = 0;
    @(negedge clk);
    mon_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
